// File: rtl/matrix_3x3_gen_pkg.sv
// Shared defaults, sync bundle type and counter-width helper for the 3x3 window generator.
package matrix_3x3_gen_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;
   localparam int DEF_PAD_VALUE  = 0;

   typedef struct packed {
      logic vsync;
      logic href;
      logic clken;
   } sync_t;

   // Bits needed to hold 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/matrix_3x3_gen_sync_delay.sv
// Two-stage registered delay of the pixel-stream sync bundle (vsync/href/clken).
module sync_delay_2
   import matrix_3x3_gen_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  sync_t i_sync,
   output sync_t o_sync_d1,
   output sync_t o_sync_d2
);

   sync_t r_d1;
   sync_t r_d2;

   // NOTE: non-blocking assignments let r_d2 capture the old r_d1, forming a real two-stage pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_d1 <= '0;
         r_d2 <= '0;
      end else begin
         r_d1 <= i_sync;
         r_d2 <= r_d1;
      end
   end

   assign o_sync_d1 = r_d1;
   assign o_sync_d2 = r_d2;

endmodule

// File: rtl/matrix_3x3_gen.sv
// Builds a registered 3x3 neighbourhood from three line-buffer taps, padding top/left borders.
module matrix_3x3_gen
   import matrix_3x3_gen_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int                    IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = DATA_WIDTH'(DEF_PAD_VALUE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pre_frame_vsync,
   input  logic                  pre_frame_href,
   input  logic                  pre_frame_clken,
   input  logic [DATA_WIDTH-1:0] taps0x,
   input  logic [DATA_WIDTH-1:0] taps1x,
   input  logic [DATA_WIDTH-1:0] taps2x,
   output logic                  post_frame_vsync,
   output logic                  post_frame_href,
   output logic                  post_frame_clken,
   output logic [DATA_WIDTH-1:0] matrix_p11,
   output logic [DATA_WIDTH-1:0] matrix_p12,
   output logic [DATA_WIDTH-1:0] matrix_p13,
   output logic [DATA_WIDTH-1:0] matrix_p21,
   output logic [DATA_WIDTH-1:0] matrix_p22,
   output logic [DATA_WIDTH-1:0] matrix_p23,
   output logic [DATA_WIDTH-1:0] matrix_p31,
   output logic [DATA_WIDTH-1:0] matrix_p32,
   output logic [DATA_WIDTH-1:0] matrix_p33,
   output logic                  matrix_border
);

   localparam int               COL_W   = clog2(IMG_WIDTH);
   localparam int               ROW_W   = clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

   sync_t w_sync_in;
   sync_t w_d1;
   sync_t w_d2;

   assign w_sync_in = '{vsync: pre_frame_vsync, href: pre_frame_href, clken: pre_frame_clken};

   sync_delay_2 u_sync_delay (
      .clk       (clk),
      .rst       (rst),
      .i_sync    (w_sync_in),
      .o_sync_d1 (w_d1),
      .o_sync_d2 (w_d2)
   );

   // d2 is simply the previous d1, so it doubles as the edge-detect history.
   logic w_vsync_rise;
   logic w_href_rise;
   logic w_href_fall;
   logic w_shift;

   assign w_vsync_rise = w_d1.vsync & ~w_d2.vsync;
   assign w_href_rise  = w_d1.href  & ~w_d2.href;
   assign w_href_fall  = ~w_d1.href &  w_d2.href;
   assign w_shift      = w_d1.clken &  w_d1.href;

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] w_col;
   logic [ROW_W-1:0] w_row;

   // Position of the pixel being loaded this cycle, with line/frame starts already applied.
   assign w_col = (w_vsync_rise | w_href_rise) ? '0 : r_col;
   assign w_row = w_vsync_rise ? '0 : r_row;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
      end else if (w_shift) begin
         r_col <= (w_col == COL_MAX) ? COL_MAX : w_col + COL_W'(1);
      end else if (w_vsync_rise | w_href_rise) begin
         r_col <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_row <= '0;
      end else if (w_vsync_rise) begin
         r_row <= '0;
      end else if (w_href_fall && (r_row != ROW_MAX)) begin
         r_row <= r_row + ROW_W'(1);
      end
   end

   logic                  w_col_eq0;
   logic                  w_col_lt2;
   logic                  w_row_lt2;
   logic [2:0]            w_row_pad;
   logic [DATA_WIDTH-1:0] w_tap [3];

   assign w_col_eq0 = (w_col == '0);
   assign w_col_lt2 = (w_col <= COL_W'(1));
   assign w_row_lt2 = (w_row <= ROW_W'(1));
   // Index 0 is the top window row (oldest line), index 2 the bottom (current line).
   assign w_row_pad = {1'b0, (w_row == '0), w_row_lt2};
   assign w_tap[0]  = taps2x;
   assign w_tap[1]  = taps1x;
   assign w_tap[2]  = taps0x;

   logic [DATA_WIDTH-1:0] r_win [3][3];
   logic                  r_border;

   // NOTE: the window is nine flops, not a RAM, so it is reset to keep stale pixels out after a mid-frame reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               r_win[r][c] <= '0;
            end
         end
         r_border <= 1'b0;
      end else if (w_shift) begin
         for (int r = 0; r < 3; r++) begin
            r_win[r][0] <= (w_row_pad[r] || w_col_lt2) ? PAD_VALUE : r_win[r][1];
            r_win[r][1] <= (w_row_pad[r] || w_col_eq0) ? PAD_VALUE : r_win[r][2];
            r_win[r][2] <= w_row_pad[r] ? PAD_VALUE : w_tap[r];
         end
         r_border <= w_row_lt2 || w_col_lt2;
      end
   end

   assign post_frame_vsync = w_d2.vsync;
   assign post_frame_href  = w_d2.href;
   assign post_frame_clken = w_d2.clken;

   assign matrix_p11    = r_win[0][0];
   assign matrix_p12    = r_win[0][1];
   assign matrix_p13    = r_win[0][2];
   assign matrix_p21    = r_win[1][0];
   assign matrix_p22    = r_win[1][1];
   assign matrix_p23    = r_win[1][2];
   assign matrix_p31    = r_win[2][0];
   assign matrix_p32    = r_win[2][1];
   assign matrix_p33    = r_win[2][2];
   assign matrix_border = r_border;

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen on a 4x3 frame, taps driven as from an ideal line buffer.
module tb_matrix_3x3_gen;

   localparam int         DW  = 8;
   localparam int         IW  = 4;
   localparam int         IH  = 3;
   localparam logic [7:0] PAD = 8'h5A;

   localparam logic [71:0] W_00   = 72'h5A5A5A5A5A5A5A5A00;
   localparam logic [71:0] W_12   = 72'h5A5A5A000102101112;
   localparam logic [71:0] W_22   = 72'h000102101112202122;
   localparam logic [71:0] W_23   = 72'h010203111213212223;
   localparam logic [71:0] W_RA   = 72'h5A5A5A5A5A5A5A5A22;
   localparam logic [71:0] W_RB   = 72'h5A5A5A5A5A5A5A2223;
   localparam logic [71:0] W_24   = 72'h020304121314222324;
   localparam logic [71:0] W_25   = 72'h030405131415232425;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pre_frame_vsync = 1'b0;
   logic          pre_frame_href  = 1'b0;
   logic          pre_frame_clken = 1'b0;
   logic [DW-1:0] taps0x = '0;
   logic [DW-1:0] taps1x = '0;
   logic [DW-1:0] taps2x = '0;
   logic          post_frame_vsync, post_frame_href, post_frame_clken;
   logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
   logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
   logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;
   logic          matrix_border;
   logic [71:0]   w_win;

   int errors = 0;
   int checks = 0;
   logic [7:0] pend0 = 8'hCC;
   logic [7:0] pend1 = 8'hCC;
   logic [7:0] pend2 = 8'hCC;

   always #5 clk = ~clk;

   matrix_3x3_gen #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (IW),
      .IMG_HEIGHT (IH),
      .PAD_VALUE  (PAD)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .pre_frame_vsync  (pre_frame_vsync),
      .pre_frame_href   (pre_frame_href),
      .pre_frame_clken  (pre_frame_clken),
      .taps0x           (taps0x),
      .taps1x           (taps1x),
      .taps2x           (taps2x),
      .post_frame_vsync (post_frame_vsync),
      .post_frame_href  (post_frame_href),
      .post_frame_clken (post_frame_clken),
      .matrix_p11       (matrix_p11),
      .matrix_p12       (matrix_p12),
      .matrix_p13       (matrix_p13),
      .matrix_p21       (matrix_p21),
      .matrix_p22       (matrix_p22),
      .matrix_p23       (matrix_p23),
      .matrix_p31       (matrix_p31),
      .matrix_p32       (matrix_p32),
      .matrix_p33       (matrix_p33),
      .matrix_border    (matrix_border)
   );

   assign w_win = {matrix_p11, matrix_p12, matrix_p13,
                   matrix_p21, matrix_p22, matrix_p23,
                   matrix_p31, matrix_p32, matrix_p33};

   function automatic logic [7:0] pix(input int r, input int c);
      return 8'(r * 16 + c);
   endfunction

   // One clock cycle: sync driven now, taps of the previously strobed pixel driven now,
   // returns 1 time unit after the rising edge that ends the cycle.
   task automatic tick(input logic vs, input logic hr, input logic ck, input int r, input int c);
      @(negedge clk);
      pre_frame_vsync = vs;
      pre_frame_href  = hr;
      pre_frame_clken = ck;
      taps0x = pend0;
      taps1x = pend1;
      taps2x = pend2;
      if (ck) begin
         pend0 = pix(r, c);
         pend1 = (r >= 1) ? pix(r - 1, c) : 8'hEE;
         pend2 = (r >= 2) ? pix(r - 2, c) : 8'hEE;
      end else begin
         pend0 = 8'hCC;
         pend1 = 8'hCC;
         pend2 = 8'hCC;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      tick(1'b0, 1'b0, 1'b0, 0, 0);
      tick(1'b0, 1'b0, 1'b0, 0, 0);
      tick(1'b1, 1'b0, 1'b0, 0, 0);
      tick(1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pre_frame_vsync = 1'b1;
         pre_frame_href  = 1'b1;
         pre_frame_clken = 1'b1;
         taps0x = 8'($urandom);
         taps1x = 8'($urandom);
         taps2x = 8'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if (w_win !== 72'h0 || matrix_border !== 1'b0 ||
             {post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b000) begin
            errors++;
            $display("FAIL reset_cycle%0d: win=%h border=%b sync=%b%b%b, expected all zero",
                     i, w_win, matrix_border, post_frame_vsync, post_frame_href, post_frame_clken);
         end
      end
      rst = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 0, 0);
      tick(1'b0, 1'b0, 1'b0, 0, 0);
      checks++;
      if (post_frame_clken !== 1'b0 || w_win !== 72'h0) begin
         errors++;
         $display("FAIL reset_release: win=%h clken=%b, expected win=0 clken=0", w_win, post_frame_clken);
      end
   endtask

   task automatic test_frame();
      start_frame();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            tick(1'b1, 1'b1, 1'b1, r, c);
            if (r == 0 && c == 1) begin
               checks++;
               if (w_win !== W_00 || matrix_border !== 1'b1 ||
                   {post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b111) begin
                  errors++;
                  $display("FAIL frame_r0c0: win=%h border=%b sync=%b%b%b, expected win=%h border=1 sync=111",
                           w_win, matrix_border, post_frame_vsync, post_frame_href, post_frame_clken, W_00);
               end
            end
            if (r == 1 && c == 3) begin
               checks++;
               if (w_win !== W_12 || matrix_border !== 1'b1 || post_frame_clken !== 1'b1) begin
                  errors++;
                  $display("FAIL frame_r1c2: win=%h border=%b clken=%b, expected win=%h border=1 clken=1",
                           w_win, matrix_border, post_frame_clken, W_12);
               end
            end
         end
         tick(1'b1, 1'b0, 1'b0, 0, 0);
         if (r == 2) begin
            checks++;
            if (w_win !== W_23 || matrix_border !== 1'b0 ||
                {post_frame_href, post_frame_clken} !== 2'b11) begin
               errors++;
               $display("FAIL frame_r2c3: win=%h border=%b href=%b clken=%b, expected win=%h border=0 href=1 clken=1",
                        w_win, matrix_border, post_frame_href, post_frame_clken, W_23);
            end
         end
         tick(1'b1, 1'b0, 1'b0, 0, 0);
         if (r == 2) begin
            checks++;
            if (w_win !== W_23 || post_frame_clken !== 1'b0 || post_frame_href !== 1'b0 ||
                post_frame_vsync !== 1'b1) begin
               errors++;
               $display("FAIL frame_blank_hold: win=%h sync=%b%b%b, expected win=%h sync=100",
                        w_win, post_frame_vsync, post_frame_href, post_frame_clken, W_23);
            end
         end
      end
   endtask

   task automatic test_gapped();
      start_frame();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            tick(1'b1, 1'b1, 1'b1, r, c);
            tick(1'b1, 1'b1, 1'b0, 0, 0);
            if (r == 0 && c == 0) begin
               checks++;
               if (w_win !== W_00 || matrix_border !== 1'b1) begin
                  errors++;
                  $display("FAIL gap_r0c0: win=%h border=%b, expected win=%h border=1", w_win, matrix_border, W_00);
               end
            end
            if (r == 2 && c == 2) begin
               checks++;
               if (w_win !== W_22 || matrix_border !== 1'b0 || post_frame_clken !== 1'b1) begin
                  errors++;
                  $display("FAIL gap_r2c2: win=%h border=%b clken=%b, expected win=%h border=0 clken=1",
                           w_win, matrix_border, post_frame_clken, W_22);
               end
            end
            tick(1'b1, 1'b1, 1'b0, 0, 0);
            if (r == 1 && c == 2) begin
               checks++;
               if (w_win !== W_12 || matrix_border !== 1'b1) begin
                  errors++;
                  $display("FAIL gap_r1c2: win=%h border=%b, expected win=%h border=1", w_win, matrix_border, W_12);
               end
            end
            if (r == 2 && c == 2) begin
               checks++;
               if (w_win !== W_22 || post_frame_clken !== 1'b0) begin
                  errors++;
                  $display("FAIL gap_hold: win=%h clken=%b, expected win=%h clken=0", w_win, post_frame_clken, W_22);
               end
            end
         end
         tick(1'b1, 1'b0, 1'b0, 0, 0);
         tick(1'b1, 1'b0, 1'b0, 0, 0);
      end
      checks++;
      if (w_win !== W_23 || matrix_border !== 1'b0) begin
         errors++;
         $display("FAIL gap_r2c3: win=%h border=%b, expected win=%h border=0", w_win, matrix_border, W_23);
      end
   endtask

   task automatic test_reset_mid();
      start_frame();
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 4; c++) tick(1'b1, 1'b1, 1'b1, r, c);
         tick(1'b1, 1'b0, 1'b0, 0, 0);
         tick(1'b1, 1'b0, 1'b0, 0, 0);
      end
      tick(1'b1, 1'b1, 1'b1, 2, 0);
      tick(1'b1, 1'b1, 1'b1, 2, 1);
      rst = 1'b1;
      tick(1'b1, 1'b1, 1'b0, 0, 0);
      rst = 1'b0;
      checks++;
      if (w_win !== 72'h0 || matrix_border !== 1'b0 ||
          {post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b000) begin
         errors++;
         $display("FAIL midrst_clear: win=%h border=%b sync=%b%b%b, expected all zero",
                  w_win, matrix_border, post_frame_vsync, post_frame_href, post_frame_clken);
      end
      tick(1'b1, 1'b1, 1'b1, 2, 2);
      tick(1'b1, 1'b1, 1'b1, 2, 3);
      checks++;
      if (w_win !== W_RA || matrix_border !== 1'b1) begin
         errors++;
         $display("FAIL midrst_as_r0c0: win=%h border=%b, expected win=%h border=1", w_win, matrix_border, W_RA);
      end
      tick(1'b1, 1'b1, 1'b0, 0, 0);
      checks++;
      if (w_win !== W_RB || matrix_border !== 1'b1) begin
         errors++;
         $display("FAIL midrst_as_r0c1: win=%h border=%b, expected win=%h border=1", w_win, matrix_border, W_RB);
      end
      tick(1'b1, 1'b0, 1'b0, 0, 0);
      tick(1'b1, 1'b0, 1'b0, 0, 0);
      start_frame();
      tick(1'b1, 1'b1, 1'b1, 0, 0);
      tick(1'b1, 1'b1, 1'b0, 0, 0);
      checks++;
      if (w_win !== W_00 || matrix_border !== 1'b1 || post_frame_clken !== 1'b1) begin
         errors++;
         $display("FAIL midrst_newframe: win=%h border=%b clken=%b, expected win=%h border=1 clken=1",
                  w_win, matrix_border, post_frame_clken, W_00);
      end
      tick(1'b1, 1'b0, 1'b0, 0, 0);
      tick(1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic test_long_line();
      start_frame();
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 6; c++) begin
            tick(1'b1, 1'b1, 1'b1, r, c);
            if (r == 2 && c == 5) begin
               checks++;
               if (w_win !== W_24 || matrix_border !== 1'b0) begin
                  errors++;
                  $display("FAIL long_r2c4: win=%h border=%b, expected win=%h border=0", w_win, matrix_border, W_24);
               end
            end
         end
         tick(1'b1, 1'b0, 1'b0, 0, 0);
         if (r == 2) begin
            checks++;
            if (w_win !== W_25 || matrix_border !== 1'b0) begin
               errors++;
               $display("FAIL long_r2c5: win=%h border=%b, expected win=%h border=0", w_win, matrix_border, W_25);
            end
         end
         tick(1'b1, 1'b0, 1'b0, 0, 0);
      end
      // Strobe with href low must not shift the window but still appears on post_frame_clken.
      tick(1'b1, 1'b0, 1'b1, 7, 7);
      tick(1'b1, 1'b0, 1'b0, 0, 0);
      checks++;
      if (w_win !== W_25 || matrix_border !== 1'b0 || post_frame_clken !== 1'b1 || post_frame_href !== 1'b0) begin
         errors++;
         $display("FAIL clken_no_href: win=%h border=%b href=%b clken=%b, expected win=%h border=0 href=0 clken=1",
                  w_win, matrix_border, post_frame_href, post_frame_clken, W_25);
      end
      tick(1'b0, 1'b0, 1'b0, 0, 0);
      tick(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_gapped();
      test_reset_mid();
      test_long_line();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/matrix_3x3_gen.md
Name: matrix_3x3_gen

Overview:
- Window-forming stage directly downstream of the 3-row line buffer in the Canny pipeline (Gaussian / Sobel front end).
- Consumes the three vertically aligned row taps plus the pixel-stream sync signals, and builds a registered 3x3 neighbourhood.
- Pads the out-of-frame window positions at the top and left borders, and flags windows that are not fully populated.
- Emits one window per accepted pixel, with delayed vsync/href/clken aligned to the window.

Parameters:
- DATA_WIDTH, 8, pixel width.
- IMG_WIDTH, 640, active pixels per line; sets column counter width and saturation.
- IMG_HEIGHT, 480, active lines per frame; sets row counter width and saturation.
- PAD_VALUE, 0, value loaded into out-of-frame window positions.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- pre_frame_vsync  in  1  frame sync, high during frame.
- pre_frame_href  in  1  line valid.
- pre_frame_clken  in  1  pixel strobe; the line buffer accepts a pixel on this cycle.
- taps0x  in  DATA_WIDTH  newest row (current line); valid one cycle after pre_frame_clken.
- taps1x  in  DATA_WIDTH  previous line, same column; valid one cycle after pre_frame_clken.
- taps2x  in  DATA_WIDTH  line before previous, same column; valid one cycle after pre_frame_clken.
- post_frame_vsync  out  1  vsync delayed 2 cycles.
- post_frame_href  out  1  href delayed 2 cycles.
- post_frame_clken  out  1  window valid strobe, clken delayed 2 cycles.
- matrix_p11..p13  out  DATA_WIDTH each  top row (from taps2x), p13 = newest column.
- matrix_p21..p23  out  DATA_WIDTH each  middle row (from taps1x).
- matrix_p31..p33  out  DATA_WIDTH each  bottom row (from taps0x); p33 = newest pixel.
- matrix_border  out  1  high when any window position is padding (row<2 or col<2).

Behaviour:
- Reset: every output and internal register goes to 0. This includes all nine matrix outputs, all sync outputs, matrix_border, the counters and the sync delay registers.
- Reset asserted mid-frame: all state clears. Pixels arriving before the next vsync rising edge are treated as row 0, col 0 onward.
- Sync pipeline: vsync/href/clken are registered twice (d1, d2). d1 is aligned with tap validity; the post_* outputs are d2.
- Latency: pixel accepted on cycle N, window containing it as p33 presented on cycle N+2, with post_frame_clken=1.
- Column counter (d1 domain):
  - cleared on the href_d1 rising edge and at vsync_d1 rising;
  - incremented after every clken_d1;
  - saturates at IMG_WIDTH-1.
- Row counter:
  - cleared on the vsync_d1 rising edge;
  - incremented on the href_d1 falling edge;
  - saturates at IMG_HEIGHT-1.
- Window shift, on clken_d1 only: pX1<=pX2, pX2<=pX3, pX3<=tap for rows X=1,2,3. Registers hold when clken_d1=0, including gaps inside a line.
- Column padding when loading:
  - col==0: pX1 and pX2 load PAD_VALUE;
  - col==1: pX1 loads PAD_VALUE.
- Row padding when loading, overriding taps:
  - row==0: the top and middle rows load PAD_VALUE in all shifted positions;
  - row==1: the top row loads PAD_VALUE.
- matrix_border: registered on clken_d1 as (row<2)||(col<2); holds otherwise.
- Bottom/right borders: no look-ahead. The window always ends at the newest pixel, and the downstream stage accounts for the 1-pixel/1-line centre offset.
- Simultaneous href falling edge and vsync rising edge: the clear wins, row=0.
- clken while href=0: ignored, no shift and no counter change; post_frame_clken still mirrors the delayed clken.

Decomposition:
- Shared package: DATA_WIDTH default, PAD_VALUE default, and the counter width function clog2(IMG_WIDTH/IMG_HEIGHT).
- One sub-module, sync_delay_2: the 2-stage registered delay of vsync/href/clken with a reset.
- Counters and the window are inline.

Test Plan:
- Reset: drive rst=1 for 3 cycles with random taps -> all outputs 0, post_frame_clken=0.
- Frame 4x3, pixels valued row*16+col, taps driven as from an ideal line buffer:
  - row 0, col 0 -> p33=0x00, all other positions PAD, border=1, at clken+2;
  - row 2, col 3 -> p11..p33 = 0x01,0x02,0x03 / 0x11,0x12,0x13 / 0x21,0x22,0x23, border=0.
- Row 1, col 2 -> top row = PAD (PAD_VALUE=0x5A set in this test), middle = 0x00..0x02, bottom = 0x10..0x12, border=1.
- Gapped clken within a line (1 on, 2 off) -> window content identical to the gapless run; outputs hold during the gaps.
- Reset pulse mid row 2, then a new vsync -> next window is treated as row 0/col 0 with full padding; no stale data appears.
- Line longer than IMG_WIDTH (6 pixels, IMG_WIDTH=4) -> column counter holds at 3; no wrap, so col<2 padding is not re-triggered.
